sobel_stream_ctrl: RTL

- AXI4-Stream frame sequencer for the Sobel convolution datapath: accepts pixel beats, drives the datapath `stall`/data/soft-reset, and re-times `conv_out_frame` onto an AXI4-Stream master with correct SOF/EOL/EOF markers.
- Hides datapath latency by discarding the first LATENCY outputs of each frame and injecting LATENCY zero flush beats after the last input beat.
- Clears datapath state between frames.

---
 rtl/sobel_stream_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sobel_stream_ctrl.sv
// Sobel stream sequencer: feeds AXI4-Stream pixel beats into the convolution datapath and re-times its output as AXI4-Stream.
// Latency: output beat k leaves on datapath advance k+LATENCY+1; the first LATENCY advances of a frame are hidden, then LATENCY zero beats flush.
// Backpressure: a held output (m_tvalid & ~m_tready) stalls the datapath and drops s_tready in the same cycle (m_tready -> s_tready is combinational).
module sobel_stream_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT,
  parameter int LATENCY         = 52,
  parameter int FRM_CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tuser,
  output logic                  m_tlast,
  output logic                  conv_stall,
  output logic                  conv_aresetn,
  output logic [DATA_WIDTH-1:0] conv_inp_frame,
  input  logic [DATA_WIDTH-1:0] conv_out_frame,
  output logic                  frame_done,
  output logic [FRM_CNT_W-1:0]  frame_cnt,
  output logic [2:0]            err_flags,
  output logic                  busy
);

  localparam int ROW_BEATS   = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int FRAME_BEATS = ROW_BEATS * IMAGE_DIM;
  localparam int ADV_MAX     = FRAME_BEATS + LATENCY;
  localparam int CNT_W       = $clog2(ADV_MAX + 1);

  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(FRAME_BEATS - 1);
  localparam logic [CNT_W-1:0] C_ADV_MAX   = CNT_W'(ADV_MAX);
  localparam logic [CNT_W-1:0] C_LAT       = CNT_W'(LATENCY);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_in_cnt;
  logic [CNT_W-1:0]     r_adv_cnt;
  logic [CNT_W-1:0]     r_out_cnt;
  logic                 r_m_tvalid;
  logic                 r_m_tuser;
  logic                 r_m_tlast;
  logic [FRM_CNT_W-1:0] r_frame_cnt;
  logic [2:0]           r_err;

  logic                  w_out_ok;
  logic                  w_adv;
  logic                  w_s_tready;
  logic [DATA_WIDTH-1:0] w_inp;
  logic                  w_frame_done;
  logic [CNT_W-1:0]      w_out_idx;
  logic                  w_row_end_in;
  logic                  w_row_end_out;

  // Output slot is free when nothing is held or the held beat leaves this cycle.
  assign w_out_ok = ~r_m_tvalid | m_tready;

  // Index of the output beat produced by the current advance (pre-increment adv_cnt minus LATENCY).
  assign w_out_idx     = r_adv_cnt - C_LAT;
  assign w_row_end_in  = (int'(r_in_cnt) % ROW_BEATS) == (ROW_BEATS - 1);
  assign w_row_end_out = (int'(w_out_idx) % ROW_BEATS) == (ROW_BEATS - 1);

  // Last beat of the frame handshakes only after every flush advance has been issued.
  assign w_frame_done = (r_state == ST_FLUSH) & r_m_tvalid & m_tready &
                        (r_out_cnt == C_LAST_BEAT) & (r_adv_cnt == C_ADV_MAX);

  // Per-state input handshake, datapath advance and datapath input selection.
  always_comb begin
    w_adv      = 1'b0;
    w_s_tready = 1'b0;
    w_inp      = '0;
    case (r_state)
      ST_IDLE:  w_s_tready = ~s_tuser & w_out_ok;
      ST_RUN: begin
        w_s_tready = w_out_ok;
        w_adv      = s_tvalid & w_out_ok;
        w_inp      = s_tdata;
      end
      ST_FLUSH: w_adv = w_out_ok & (r_adv_cnt != C_ADV_MAX);
      default:  ;
    endcase
  end

  // Frame sequencing, beat counters and sticky protocol error flags.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_CLEAR;
      r_in_cnt  <= '0;
      r_adv_cnt <= '0;
      r_err     <= '0;
    end else begin
      if (w_adv) r_adv_cnt <= r_adv_cnt + CNT_W'(1);
      case (r_state)
        ST_CLEAR: begin
          r_in_cnt  <= '0;
          r_adv_cnt <= '0;
          r_state   <= ST_IDLE;
        end
        ST_IDLE: begin
          if (s_tvalid && w_s_tready) r_err[0] <= 1'b1;
          // The SOF beat itself is taken on the first RUN cycle.
          if (s_tvalid && s_tuser && enable && w_out_ok) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_adv) begin
            r_in_cnt <= r_in_cnt + CNT_W'(1);
            if (s_tuser && (r_in_cnt != '0)) r_err[1] <= 1'b1;
            if (s_tlast != w_row_end_in) r_err[2] <= 1'b1;
            // Frame length comes from the counter only; tlast is advisory.
            if (r_in_cnt == C_LAST_BEAT) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_frame_done) r_state <= ST_CLEAR;
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
    end else if (w_frame_done) begin
      r_frame_cnt <= r_frame_cnt + FRM_CNT_W'(1);
    end
  end

  // Output beat qualifiers; data itself comes straight from the datapath register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_out_cnt  <= '0;
    end else if (w_adv && (r_adv_cnt >= C_LAT)) begin
      r_m_tvalid <= 1'b1;
      r_out_cnt  <= w_out_idx;
      r_m_tuser  <= (w_out_idx == '0);
      r_m_tlast  <= w_row_end_out;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_tready       = w_s_tready;
  assign conv_stall     = ~w_adv;
  assign conv_aresetn   = (r_state != ST_CLEAR);
  assign conv_inp_frame = w_inp;
  assign m_tvalid       = r_m_tvalid;
  assign m_tuser        = r_m_tuser;
  assign m_tlast        = r_m_tlast;
  assign m_tdata        = conv_out_frame;
  assign frame_done     = w_frame_done;
  assign frame_cnt      = r_frame_cnt;
  assign err_flags      = r_err;
  assign busy           = (r_state != ST_IDLE);

endmodule
